// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: bring-up / self-check sequencer for a shared NAND-built
// gate unit. It sweeps gate codes 0..NUM_GATES-1 over all four {a,b} vectors,
// holds each vector for SETTLE_CYCLES before sampling y_i, builds a 4-bit truth
// table per gate and compares it with the built-in expected table.
// Optional build macro: GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first
// gate whose table mismatches (remaining gates stay untested, reported as 0).

module gate_sweep_ctrl #(
    parameter int NUM_GATES     = 7,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic [2:0]             gate_sel_o,
    output logic                   a_o,
    output logic                   b_o,
    input  logic                   y_i,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [NUM_GATES-1:0]   fail_mask,
    output logic [4*NUM_GATES-1:0] truth_table
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [2:0] GATE_LAST   = 3'(NUM_GATES - 1);
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    // Reference truth tables, bit index = {a,b}; unused codes have no table.
    function automatic logic [3:0] expected_table(input logic [2:0] code);
        logic [3:0] tbl;
        case (code)
            3'd0:    tbl = 4'b0111;   // NAND
            3'd1:    tbl = 4'b1000;   // AND
            3'd2:    tbl = 4'b1110;   // OR
            3'd3:    tbl = 4'b0001;   // NOR
            3'd4:    tbl = 4'b0110;   // XOR
            3'd5:    tbl = 4'b1001;   // XNOR
            3'd6:    tbl = 4'b0011;   // NOT a
            default: tbl = 4'b0000;
        endcase
        return tbl;
    endfunction

    state_t                   r_state;
    logic [2:0]               r_gate;
    logic [1:0]               r_vec;
    logic [3:0]               r_settle_cnt;
    logic [2:0]               r_gate_sel;
    logic                     r_a;
    logic                     r_b;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic [NUM_GATES-1:0]     r_fail_mask;
    logic [4*NUM_GATES-1:0]   r_truth_table;

    logic [3:0]               w_cur_table;
    logic                     w_mismatch;
    logic [NUM_GATES-1:0]     w_fail_mask_nxt;
    logic [4:0]               w_tt_idx;
    logic [1:0]               w_vec_inc;
    logic [2:0]               w_gate_inc;

    // Compare the current gate's captured table and form the updated fail mask.
    always_comb begin
        w_cur_table     = r_truth_table[int'(r_gate)*4 +: 4];
        w_tt_idx        = {r_gate, r_vec};
        w_vec_inc       = r_vec + 2'd1;
        w_gate_inc      = r_gate + 3'd1;
        w_mismatch      = 1'b0;
        w_fail_mask_nxt = r_fail_mask;
        if (w_cur_table != expected_table(r_gate)) begin
            w_mismatch      = 1'b1;
            w_fail_mask_nxt = r_fail_mask | (NUM_GATES'(1) << r_gate);
        end else begin
            w_mismatch      = 1'b0;
            w_fail_mask_nxt = r_fail_mask;
        end
    end

    // Sweep FSM: drives the gate unit, captures y_i and records results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gate        <= 3'd0;
            r_vec         <= 2'd0;
            r_settle_cnt  <= 4'd0;
            r_gate_sel    <= 3'd0;
            r_a           <= 1'b0;
            r_b           <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_mask   <= '0;
            r_truth_table <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state       <= DRIVE;
                        r_gate        <= 3'd0;
                        r_vec         <= 2'd0;
                        r_gate_sel    <= 3'd0;
                        r_a           <= 1'b0;
                        r_b           <= 1'b0;
                        r_busy        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_fail_mask   <= '0;
                        r_truth_table <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DRIVE: begin
                    // Drives were already loaded on entry; only route onward.
                    r_settle_cnt <= 4'd0;
                    if (SETTLE_CYCLES > 0) begin
                        r_state <= SETTLE;
                    end else begin
                        r_state <= SAMPLE;
                    end
                end
                SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    r_truth_table[w_tt_idx] <= y_i;
                    if (r_vec == 2'd3) begin
                        r_state <= CHECK;
                    end else begin
                        r_vec   <= w_vec_inc;
                        r_a     <= w_vec_inc[1];
                        r_b     <= w_vec_inc[0];
                        r_state <= DRIVE;
                    end
                end
                CHECK: begin
                    r_fail_mask <= w_fail_mask_nxt;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                    if (w_mismatch || (r_gate == GATE_LAST)) begin
`else
                    if (r_gate == GATE_LAST) begin
`endif
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_pass  <= ~|w_fail_mask_nxt;
                    end else begin
                        r_gate     <= w_gate_inc;
                        r_gate_sel <= w_gate_inc;
                        r_vec      <= 2'd0;
                        r_a        <= 1'b0;
                        r_b        <= 1'b0;
                        r_state    <= DRIVE;
                    end
                end
                DONE: begin
                    // Start is deliberately not looked at here.
                    r_state    <= IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_gate     <= 3'd0;
                    r_vec      <= 2'd0;
                    r_gate_sel <= 3'd0;
                    r_a        <= 1'b0;
                    r_b        <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign gate_sel_o  = r_gate_sel;
    assign a_o         = r_a;
    assign b_o         = r_b;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_mask   = r_fail_mask;
    assign truth_table = r_truth_table;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a behavioural gate unit that can be
// switched between correct and faulty behaviour.
module tb_gate_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  gate_sel_o;
    logic        a_o, b_o, y_i;
    logic        busy, done, pass;
    logic [6:0]  fail_mask;
    logic [27:0] truth_table;

    int checks = 0;
    int errors = 0;
    int fault_mode = 0;   // 0 good, 1 y stuck 0, 2 code4 acts as XNOR, 3 code2 stuck 0
    int cyc;

    localparam logic [27:0] GOOD_TT = {4'b0011, 4'b1001, 4'b0110, 4'b0001,
                                       4'b1110, 4'b1000, 4'b0111};

    gate_sweep_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .gate_sel_o(gate_sel_o), .a_o(a_o), .b_o(b_o), .y_i(y_i),
        .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .truth_table(truth_table)
    );

    always #5 clk = ~clk;

    // Behavioural gate unit with injectable faults.
    always_comb begin
        case (gate_sel_o)
            3'd0:    y_i = ~(a_o & b_o);
            3'd1:    y_i = a_o & b_o;
            3'd2:    y_i = a_o | b_o;
            3'd3:    y_i = ~(a_o | b_o);
            3'd4:    y_i = a_o ^ b_o;
            3'd5:    y_i = ~(a_o ^ b_o);
            3'd6:    y_i = ~a_o;
            default: y_i = 1'b0;
        endcase
        if (fault_mode == 1) y_i = 1'b0;
        if (fault_mode == 2 && gate_sel_o == 3'd4) y_i = ~(a_o ^ b_o);
        if (fault_mode == 3 && gate_sel_o == 3'd2) y_i = 1'b0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, optionally re-pulse it at cycles p1/p2, wait (bounded) for done.
    // On return the bench sits mid-cycle in the DONE cycle; n = its cycle number.
    task automatic sweep(input int p1, input int p2, output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 400) begin
            start = (n == p1 || n == p2);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_drv"}, 64'({gate_sel_o, a_o, b_o}), 64'd0);
    endtask

    initial begin
        int extra;
        // Reset state
        repeat (3) @(negedge clk);
        check_idle("rst");
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fm", 64'(fail_mask), 64'd0);
        chk("rst_tt", 64'(truth_table), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good gate unit, full sweep
        sweep(0, 0, cyc);
        chk("good_cycles", 64'(cyc), 64'd120);
        chk("good_busy", 64'(busy), 64'd1);
        chk("good_pass", 64'(pass), 64'd1);
        chk("good_fm", 64'(fail_mask), 64'd0);
        chk("good_tt", 64'(truth_table), 64'(GOOD_TT));
        // start during the DONE cycle must be ignored
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_idle("after_done");
        chk("hold_pass", 64'(pass), 64'd1);
        @(negedge clk);
        chk("done_start_ignored", 64'(busy), 64'd0);

        // y stuck at 0
        fault_mode = 1;
        sweep(0, 0, cyc);
        chk("y0_cycles", 64'(cyc), 64'd120);
        chk("y0_pass", 64'(pass), 64'd0);
        chk("y0_fm", 64'(fail_mask), 64'h7f);
        chk("y0_tt", 64'(truth_table), 64'd0);
        @(negedge clk);

        // code4 behaves as XNOR
        fault_mode = 2;
        sweep(0, 0, cyc);
        chk("xnor_pass", 64'(pass), 64'd0);
        chk("xnor_fm", 64'(fail_mask), 64'h10);
        chk("xnor_tt4", 64'(truth_table[19:16]), 64'h9);
        @(negedge clk);

        // starts mid-sweep ignored, single done
        fault_mode = 0;
        sweep(10, 60, cyc);
        chk("ign_cycles", 64'(cyc), 64'd120);
        chk("ign_pass", 64'(pass), 64'd1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("ign_extra_done", 64'(extra), 64'd0);
        sweep(0, 0, cyc);
        chk("again_cycles", 64'(cyc), 64'd120);
        chk("again_tt", 64'(truth_table), 64'(GOOD_TT));
        chk("again_fm", 64'(fail_mask), 64'd0);
        @(negedge clk);

        // rst at cycle 30 aborts, then rst beats start
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("abort");
        chk("abort_tt", 64'(truth_table), 64'd0);
        chk("abort_fm", 64'(fail_mask), 64'd0);
        start = 1'b1;
        @(negedge clk);
        chk("rst_wins", 64'(busy), 64'd0);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_wins_idle", 64'(busy), 64'd0);
        sweep(0, 0, cyc);
        chk("fresh_cycles", 64'(cyc), 64'd120);
        chk("fresh_pass", 64'(pass), 64'd1);
        @(negedge clk);

        // start held high restarts one cycle after DONE
        start = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_done", 64'(done), 64'd1);
        @(negedge clk);
        chk("held_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("held_restart", 64'(busy), 64'd1);
        chk("held_cleared", 64'(pass), 64'd0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        // early stop at faulty code2
        fault_mode = 3;
        sweep(0, 0, cyc);
        chk("stop_cycles", 64'(cyc), 64'd52);
        chk("stop_fm", 64'(fail_mask), 64'h04);
        chk("stop_tt_hi", 64'(truth_table[27:12]), 64'd0);
        chk("stop_pass", 64'(pass), 64'd0);
        @(negedge clk);
`else
        // code2 faulty without early stop: full sweep
        fault_mode = 3;
        sweep(0, 0, cyc);
        chk("nostop_cycles", 64'(cyc), 64'd120);
        chk("nostop_fm", 64'(fail_mask), 64'h04);
        chk("nostop_tt2", 64'(truth_table[11:8]), 64'd0);
        chk("nostop_tt6", 64'(truth_table[27:24]), 64'h3);
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
